core_c1_dtcm_ctrl: RTL
======================

# core_c1_dtcm_ctrl

Data tightly-coupled memory responder for the C1 core. Receives load and store requests from the execute-stage load/store unit and generates byte strobes from address and size. Stores pass through a one-entry write buffer; loads are served from a synchronous single-port RAM, right-aligned to byte 0, with a one-cycle pipeline pause. Sits between the EXU load/store path and the on-chip data RAM.

## Interface
- ADDR_WIDTH, 12, word-address bits (2^ADDR_WIDTH words, 16 KB default)
- BASE_ADDR, 32'h2000_0000, region base; bits [31:ADDR_WIDTH+2] decode hit

Ports:
- clk  in  1  core clock
- rst  in  1  reset, asynchronous, active-high
- lsu_store_en  in  1  store request, one cycle per store instruction
- lsu_store_addr  in  32  store byte address
- lsu_store_data  in  32  store data, already lane-replicated by the LSU
- lsu_store_size  in  2  00=byte, 01=half, 10=word
- lsu_load_en  in  1  load request, held high while the load instruction is in EXU
- lsu_load_addr  in  32  load byte address
- lsu_load_size  in  2  same encoding as store size
- mem_pause  out  1  stall request to EXU
- lsu_load_valid  out  1  lsu_load_data valid this cycle
- lsu_load_data  out  32  word shifted right by addr[1:0]*8, zero-filled
- misalign_err  out  1  sticky misalignment flag
- err_clr  in  1  clears misalign_err

## Operation
- FSM states: IDLE, LD_DATA.
- IDLE with lsu_load_en=1 and region hit:
  - issue RAM read of word addr[ADDR_WIDTH+1:2]
  - mem_pause=1 (combinational)
  - next state LD_DATA
- LD_DATA:
  - lsu_load_valid=1, mem_pause=0; lsu_load_en is ignored
  - next state IDLE unconditionally
- Load miss (outside region): no pause, lsu_load_valid=1 in the same cycle, data 0.
- Byte strobes:
  - SB: 4'b0001<<addr[1:0]
  - SH: 4'b0011<<(addr[1]*2)
  - SW: 4'b1111
  - write-lane data is lsu_store_data unchanged
- Write buffer (single entry: word address, data, strobe, valid):
  - lsu_store_en with region hit captures an entry at the clock edge.
  - Any existing entry drains to RAM in the same cycle.
  - A RAM read takes priority over draining; the buffer holds during a read cycle.
  - The buffer drains in any cycle without a read.
- Forwarding: in LD_DATA, if the buffer is valid and its word address equals the load word address, the strobed buffer bytes replace RAM bytes before alignment.
- A store outside the region is dropped silently.
- Store and load never occur in the same cycle (LSU guarantee). If both are asserted, the store is ignored.

## Timing
- Reset values:
  - state IDLE, buffer valid 0
  - lsu_load_valid 0, lsu_load_data 0, misalign_err 0
  - mem_pause is forced 0 while rst=1
  - RAM contents are not reset
- Load latency: request in cycle N, data in cycle N+1. The EXU sees one pause cycle.
- Back-to-back loads: the second request in cycle N+2 is treated as a new request.
- Store latency: the RAM is updated no later than the first non-read cycle after capture. A load issued the cycle after a store returns the stored bytes via forwarding.
- Reset mid-load: the FSM returns to IDLE, a pending buffer entry is lost, and no lsu_load_valid is produced.
- misalign_err:
  - set on the edge after a misaligned request
  - err_clr and a new error in the same cycle: set wins

## Configuration
- C1_DTCM_MISALIGN_CHK_EN defined:
  - misaligned requests are SH/LH with addr[0]=1, and SW/LW with addr[1:0]≠0
  - a misaligned store is dropped
  - a misaligned load still takes the LD_DATA cycle but returns data 0
  - misalign_err is set
- Undefined:
  - half accesses mask addr[0], word accesses mask addr[1:0]
  - misalign_err is tied 0

## Structure
- Package core_c1_pkg holds:
  - size constants SIZE_B=2'b00, SIZE_H=2'b01, SIZE_W=2'b10
  - FSM state type for IDLE/LD_DATA
  - the strobe-generation function
- Sub-module core_c1_dtcm_ram: single-port synchronous RAM with 4 byte-write enables, 2^ADDR_WIDTH×32. Read data is registered.

## Test plan
- SW 0x2000_0010 = 0xDEADBEEF, LW same address two cycles later → mem_pause high for 1 cycle, lsu_load_data=0xDEADBEEF with lsu_load_valid.
- SB 0x2000_0013 data 0x5A5A5A5A onto word 0x11223344, LW 0x2000_0010 → 0x5A223344; LB 0x2000_0013 → lsu_load_data=0x0000005A.
- SH 0x2000_0022 = 0xBEEF immediately followed by LH 0x2000_0022 (buffer not yet drained) → forwarded 0x0000BEEF.
- With C1_DTCM_MISALIGN_CHK_EN: SW 0x2000_0001 → RAM unchanged, misalign_err=1; err_clr pulse → 0.
- LW 0x1000_0000 (miss) → no pause, lsu_load_valid same cycle, data 0; SW to 0x1000_0000 → no RAM write.
- rst asserted during LD_DATA → lsu_load_valid=0, state IDLE, mem_pause=0 during reset.

Source files
------------

// File: rtl/core_c1_pkg.sv
// Shared types and helpers for the C1 data TCM controller.
// Latency: none (package only).
// Backpressure: none (package only).
package core_c1_pkg;

    localparam logic [1:0] SIZE_B = 2'b00;
    localparam logic [1:0] SIZE_H = 2'b01;
    localparam logic [1:0] SIZE_W = 2'b10;

    typedef enum logic {
        IDLE    = 1'b0,
        LD_DATA = 1'b1
    } dtcm_state_t;

    // Byte-lane write enables for an access of the given size at byte offset offs.
    // Half accesses ignore offs[0]; word (and the unused 2'b11 code) write all lanes.
    function automatic logic [3:0] byte_strobe(input logic [1:0] size, input logic [1:0] offs);
        case (size)
            SIZE_B:  return 4'b0001 << offs;
            SIZE_H:  return offs[1] ? 4'b1100 : 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

    // Byte offset actually used to right-align load data (low bits masked by size).
    function automatic logic [1:0] align_offs(input logic [1:0] size, input logic [1:0] offs);
        case (size)
            SIZE_B:  return offs;
            SIZE_H:  return {offs[1], 1'b0};
            default: return 2'b00;
        endcase
    endfunction

    // True when the access is not naturally aligned for its size.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] offs);
        case (size)
            SIZE_B:  return 1'b0;
            SIZE_H:  return offs[0];
            default: return |offs;
        endcase
    endfunction

endpackage

// File: rtl/core_c1_dtcm_ctrl_if.sv
// LSU <-> data TCM request/response bundle.
// Latency: wires only.
// Backpressure: mem_pause stalls the EXU while a load is in flight.
interface core_c1_dtcm_ctrl_if;

    logic        lsu_store_en;
    logic [31:0] lsu_store_addr;
    logic [31:0] lsu_store_data;
    logic [1:0]  lsu_store_size;
    logic        lsu_load_en;
    logic [31:0] lsu_load_addr;
    logic [1:0]  lsu_load_size;
    logic        mem_pause;
    logic        lsu_load_valid;
    logic [31:0] lsu_load_data;
    logic        misalign_err;
    logic        err_clr;

    // LSU side: issues requests, receives pause and load data.
    modport master (
        output lsu_store_en, lsu_store_addr, lsu_store_data, lsu_store_size,
        output lsu_load_en, lsu_load_addr, lsu_load_size, err_clr,
        input  mem_pause, lsu_load_valid, lsu_load_data, misalign_err
    );

    // TCM controller side.
    modport slave (
        input  lsu_store_en, lsu_store_addr, lsu_store_data, lsu_store_size,
        input  lsu_load_en, lsu_load_addr, lsu_load_size, err_clr,
        output mem_pause, lsu_load_valid, lsu_load_data, misalign_err
    );

endinterface

// File: rtl/core_c1_dtcm_ram.sv
// Single-port synchronous data RAM, 2^ADDR_WIDTH x 32 with per-byte write enables.
// Latency: read data registered, valid the cycle after rd_en.
// Backpressure: none; caller must not read and write in the same cycle.
module core_c1_dtcm_ram #(
    parameter int unsigned ADDR_WIDTH = 12
) (
    input  logic                  clk,
    input  logic                  rd_en,
    input  logic [3:0]            wr_en,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [31:0]           wdata,
    output logic [31:0]           rdata
);

    logic [31:0] mem [0:(2**ADDR_WIDTH)-1];

    // Byte-masked write and registered read; contents are deliberately not reset.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (wr_en[i]) begin
                mem[addr][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
        if (rd_en) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/core_c1_dtcm_ctrl.sv
// Data TCM responder: one-entry store buffer, single-pause loads with store forwarding.
// Latency: region-hit load data 1 cycle after request; misses answer in the same cycle.
// Backpressure: mem_pause held for the request cycle of each hit load. Option macro: C1_DTCM_MISALIGN_CHK_EN.
module core_c1_dtcm_ctrl
    import core_c1_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 12,
    parameter logic [31:0] BASE_ADDR  = 32'h2000_0000
) (
    input  logic                 clk,
    input  logic                 rst,
    core_c1_dtcm_ctrl_if.slave   lsu
);

    localparam int unsigned HIT_LSB = ADDR_WIDTH + 2;

    function automatic logic in_region(input logic [31:0] a);
        return a[31:HIT_LSB] == BASE_ADDR[31:HIT_LSB];
    endfunction

    dtcm_state_t           state;
    logic [ADDR_WIDTH-1:0] ld_word_q;
    logic [1:0]            ld_offs_q;
    logic                  ld_mis_q;

    logic                  wb_vld;
    logic [ADDR_WIDTH-1:0] wb_word;
    logic [31:0]           wb_dat;
    logic [3:0]            wb_strb;

    logic                  ld_hit;
    logic                  st_hit;
    logic                  ld_mis;
    logic                  st_mis;
    logic                  ld_req;
    logic                  st_go;
    logic                  wb_drain;
    logic [ADDR_WIDTH-1:0] ram_addr;
    logic [31:0]           ram_rdata;
    logic [31:0]           merged;

    assign ld_hit = in_region(lsu.lsu_load_addr);
    assign st_hit = in_region(lsu.lsu_store_addr);

`ifdef C1_DTCM_MISALIGN_CHK_EN
    assign ld_mis = is_misaligned(lsu.lsu_load_size, lsu.lsu_load_addr[1:0]);
    assign st_mis = is_misaligned(lsu.lsu_store_size, lsu.lsu_store_addr[1:0]);
`else
    assign ld_mis = 1'b0;
    assign st_mis = 1'b0;
`endif

    // A load accepted in IDLE owns the RAM port this cycle; the buffer waits.
    assign ld_req   = !rst && (state == IDLE) && lsu.lsu_load_en && ld_hit;
    // Loads win over stores if the LSU ever asserts both.
    assign st_go    = !rst && lsu.lsu_store_en && !lsu.lsu_load_en && st_hit && !st_mis;
    assign wb_drain = wb_vld && !ld_req;
    assign ram_addr = ld_req ? lsu.lsu_load_addr[ADDR_WIDTH+1:2] : wb_word;

    assign lsu.mem_pause = ld_req;

    // Load FSM: capture word address / alignment on request, answer next cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            ld_word_q <= '0;
            ld_offs_q <= '0;
            ld_mis_q  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (ld_req) begin
                        state     <= LD_DATA;
                        ld_word_q <= lsu.lsu_load_addr[ADDR_WIDTH+1:2];
                        ld_offs_q <= align_offs(lsu.lsu_load_size, lsu.lsu_load_addr[1:0]);
                        ld_mis_q  <= ld_mis;
                    end
                end
                LD_DATA: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // One-entry store buffer: a new store overwrites it while the old entry drains.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wb_vld  <= 1'b0;
            wb_word <= '0;
            wb_dat  <= '0;
            wb_strb <= '0;
        end else if (st_go) begin
            wb_vld  <= 1'b1;
            wb_word <= lsu.lsu_store_addr[ADDR_WIDTH+1:2];
            wb_dat  <= lsu.lsu_store_data;
            wb_strb <= byte_strobe(lsu.lsu_store_size, lsu.lsu_store_addr[1:0]);
        end else if (wb_drain) begin
            wb_vld  <= 1'b0;
        end
    end

    core_c1_dtcm_ram #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_ram (
        .clk   (clk),
        .rd_en (ld_req),
        .wr_en (wb_drain ? wb_strb : 4'b0000),
        .addr  (ram_addr),
        .wdata (wb_dat),
        .rdata (ram_rdata)
    );

    // Overlay buffered store bytes on the RAM word when the buffer targets the loaded word.
    always_comb begin
        merged = ram_rdata;
        if (wb_vld && (wb_word == ld_word_q)) begin
            for (int i = 0; i < 4; i++) begin
                if (wb_strb[i]) begin
                    merged[8*i +: 8] = wb_dat[8*i +: 8];
                end
            end
        end
    end

    // Load response: aligned RAM data in LD_DATA, immediate zero for region misses.
    always_comb begin
        lsu.lsu_load_valid = 1'b0;
        lsu.lsu_load_data  = '0;
        if (!rst) begin
            if (state == LD_DATA) begin
                lsu.lsu_load_valid = 1'b1;
                if (!ld_mis_q) begin
                    lsu.lsu_load_data = merged >> {ld_offs_q, 3'b000};
                end
            end else if (lsu.lsu_load_en && !ld_hit) begin
                lsu.lsu_load_valid = 1'b1;
            end
        end
    end

`ifdef C1_DTCM_MISALIGN_CHK_EN
    logic mis_evt;
    logic err_q;

    assign mis_evt = (lsu.lsu_store_en && !lsu.lsu_load_en && st_hit && st_mis) ||
                     ((state == IDLE) && lsu.lsu_load_en && ld_hit && ld_mis);

    // Sticky misalignment flag; a new error in the clear cycle keeps it set.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if (mis_evt) begin
            err_q <= 1'b1;
        end else if (lsu.err_clr) begin
            err_q <= 1'b0;
        end
    end

    assign lsu.misalign_err = err_q;
`else
    assign lsu.misalign_err = 1'b0;
`endif

endmodule
